// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754 divider, radix-2 restoring, one quotient bit per cycle, tagged valid/ready.
// Define FPDIV_SUBNORM_EN for gradual underflow; without it subnormal inputs and tiny results flush to zero.
module fp_div_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_y,
    output logic [TAG_W-1:0]     out_tag,
    output logic [4:0]           out_flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 3;
    localparam int XW = EXP_W + 4;
    localparam int QW = MAN_W + 3;
    localparam int RW = MAN_W + 2;
    localparam int CW = $clog2(MAN_W + 4);
    localparam logic signed [XW-1:0] BIAS = XW'(2**(EXP_W-1) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'(2**EXP_W - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_t;

    state_t               state;
    logic [W-1:0]         a_r, b_r;
    logic [TAG_W-1:0]     tag_r;
    logic signed [EW-1:0] ediff;
    logic [MAN_W:0]       mb;
    logic [RW-1:0]        rem;
    logic [QW-1:0]        q;
    logic [CW-1:0]        cnt;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             sign_q;
    logic             a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, a_zero, b_zero;

    assign ea     = a_r[W-2 -: EXP_W];
    assign eb     = b_r[W-2 -: EXP_W];
    assign fa     = a_r[MAN_W-1:0];
    assign fb     = b_r[MAN_W-1:0];
    assign sign_q = a_r[W-1] ^ b_r[W-1];
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_snan = a_nan & ~fa[MAN_W-1];
    assign b_snan = b_nan & ~fb[MAN_W-1];
`ifdef FPDIV_SUBNORM_EN
    assign a_zero = ~(|ea) & ~(|fa);
    assign b_zero = ~(|eb) & ~(|fb);
`else
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);
`endif

    logic [MAN_W:0]       ma_n, mb_n;
    logic signed [EW-1:0] ea_n, eb_n;
`ifdef FPDIV_SUBNORM_EN
    localparam int LZW = $clog2(MAN_W + 1);
    logic [LZW-1:0] sh_a, sh_b;

    function automatic logic [LZW-1:0] lzc(input logic [MAN_W-1:0] f);
        lzc = '0;
        for (int i = 0; i < MAN_W; i++)
            if (f[i]) lzc = LZW'(MAN_W - 1 - i);
    endfunction
`endif

    // Subnormals get their leading one moved to the hidden position; exponent becomes -lz.
    always_comb begin
        ma_n = {1'b1, fa};
        mb_n = {1'b1, fb};
        ea_n = EW'(ea);
        eb_n = EW'(eb);
`ifdef FPDIV_SUBNORM_EN
        sh_a = lzc(fa) + LZW'(1);
        sh_b = lzc(fb) + LZW'(1);
        if (ea == '0) begin
            ma_n = {1'b0, fa} << sh_a;
            ea_n = EW'(1) - EW'(sh_a);
        end
        if (eb == '0) begin
            mb_n = {1'b0, fb} << sh_b;
            eb_n = EW'(1) - EW'(sh_b);
        end
`endif
    end

    logic         spec_hit;
    logic [W-1:0] spec_y;
    logic [4:0]   spec_f;

    always_comb begin
        spec_hit = 1'b1;
        spec_y   = QNAN;
        spec_f   = 5'b0;
        if (a_nan | b_nan)
            spec_f = {a_snan | b_snan, 4'b0};
        else if ((a_zero & b_zero) | (a_inf & b_inf))
            spec_f = 5'b10000;
        else if (a_inf)
            spec_y = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (b_inf | a_zero)
            spec_y = {sign_q, {(W-1){1'b0}}};
        else if (b_zero) begin
            spec_y = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_f = 5'b01000;
        end else
            spec_hit = 1'b0;
    end

    logic          ge;
    logic [RW-1:0] diff;
    assign ge   = rem >= {1'b0, mb};
    assign diff = rem - {1'b0, mb};

    logic [MAN_W:0]       m_n;
    logic                 g_n, s_n, nx, tiny, uf, ovf;
    logic signed [XW-1:0] e_n, e_b, e_f;
    logic [MAN_W+1:0]     rnd;
    logic [W-1:0]         r_y;
    logic [4:0]           r_f;
`ifdef FPDIV_SUBNORM_EN
    logic [RW-1:0] sig, sig_sh;
    logic [XW-1:0] sh;
    logic          lost;
`endif

    always_comb begin
        if (q[QW-1]) begin
            m_n = q[QW-1:2];
            g_n = q[1];
            s_n = q[0] | (|rem);
            e_n = $signed({ediff[EW-1], ediff}) + BIAS;
        end else begin
            m_n = q[QW-2:1];
            g_n = q[0];
            s_n = |rem;
            e_n = $signed({ediff[EW-1], ediff}) + BIAS - XW'(1);
        end
        e_b = e_n - XW'(1);
`ifdef FPDIV_SUBNORM_EN
        tiny   = e_n[XW-1] | (e_n == '0);
        sh     = XW'(1) - e_n;
        if (sh > XW'(RW)) sh = XW'(RW);
        sig    = {m_n, g_n};
        sig_sh = sig >> sh;
        lost   = |(sig & ~({RW{1'b1}} << sh));
        if (tiny) begin
            m_n = sig_sh[RW-1:1];
            g_n = sig_sh[0];
            s_n = s_n | lost;
            e_b = '0;
        end
`endif
        rnd = {1'b0, m_n} + {{(MAN_W+1){1'b0}}, g_n & (s_n | m_n[0])};
        nx  = g_n | s_n;
        // Integer part of the rounded significand (0, 1 or 2) folds carry and min-normal promotion.
        e_f = e_b + XW'(rnd[MAN_W+1:MAN_W]);
`ifdef FPDIV_SUBNORM_EN
        uf = tiny & ~rnd[MAN_W] & nx;
`else
        tiny = e_f[XW-1] | (e_f == '0);
        uf   = tiny;
`endif
        ovf = e_f >= EMAX;
        r_y = {sign_q, e_f[EXP_W-1:0], rnd[MAN_W-1:0]};
        r_f = {3'b000, uf, nx};
        if (ovf) begin
            r_y = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_f = 5'b00101;
        end
`ifndef FPDIV_SUBNORM_EN
        if (tiny) begin
            r_y = {sign_q, {(W-1){1'b0}}};
            r_f = 5'b00011;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r      <= in_a;
                    b_r      <= in_b;
                    tag_r    <= in_tag;
                    in_ready <= 1'b0;
                    state    <= PREP;
                end
                PREP: begin
                    ediff <= ea_n - eb_n;
                    mb    <= mb_n;
                    rem   <= {1'b0, ma_n};
                    q     <= '0;
                    cnt   <= '0;
                    if (spec_hit) begin
                        out_y     <= spec_y;
                        out_flags <= spec_f;
                        out_tag   <= tag_r;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else
                        state <= ITER;
                end
                ITER: begin
                    rem <= ge ? {diff[RW-2:0], 1'b0} : {rem[RW-2:0], 1'b0};
                    q   <= {q[QW-2:0], ge};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(MAN_W + 2)) state <= ROUND;
                end
                ROUND: begin
                    out_y     <= r_y;
                    out_flags <= r_f;
                    out_tag   <= tag_r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_iter.sv
// Directed-vector bench for fp_div_iter (fp32 configuration); results depend on FPDIV_SUBNORM_EN.
module tb_fp_div_iter;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_tag;
    logic [4:0]  out_flags;

    int checks   = 0;
    int failures = 0;

    fp_div_iter #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request from IDLE; returns the cycle out_valid first rises (-1 on timeout)
    // and how many cycles in_ready was seen high while waiting.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         output int lat, output int rdy_hi);
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; rdy_hi = 0;
        while (!out_valid && lat <= 100) begin
            if (in_ready) rdy_hi++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_y !== 32'h0) begin failures++; $display("FAIL reset_out_y: got %h expected 0", out_y); end
        checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
        checks++; if (out_flags !== 5'h0) begin failures++; $display("FAIL reset_out_flags: got %b expected 0", out_flags); end
    endtask

    task automatic test_normal();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] vy [4];
        int lat, rh;
        va = '{32'h40C00000, 32'hC0C00000, 32'h3F800000, 32'h41200000};
        vb = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h40A00000};
        vy = '{32'h40400000, 32'hC0400000, 32'h3F800000, 32'h40000000};
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], 4'(i + 5), lat, rh);
            checks++; if (lat !== 29) begin failures++; $display("FAIL normal%0d_latency: got %0d expected 29", i, lat); end
            checks++; if (rh !== 0) begin failures++; $display("FAIL normal%0d_in_ready_busy: got %0d high cycles expected 0", i, rh); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL normal%0d_in_ready_done: got %b expected 0", i, in_ready); end
            checks++; if (out_y !== vy[i]) begin failures++; $display("FAIL normal%0d_y: got %h expected %h", i, out_y, vy[i]); end
            checks++; if (out_flags !== 5'b0) begin failures++; $display("FAIL normal%0d_flags: got %b expected 00000", i, out_flags); end
            checks++; if (out_tag !== 4'(i + 5)) begin failures++; $display("FAIL normal%0d_tag: got %h expected %h", i, out_tag, 4'(i + 5)); end
            consume();
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL normal%0d_release: got ready=%b valid=%b expected 1/0", i, in_ready, out_valid); end
        end
    endtask

    task automatic test_hold();
        int lat, rh;
        issue(32'h3F800000, 32'h40400000, 4'hA, lat, rh);
        checks++; if (lat !== 29) begin failures++; $display("FAIL hold_latency: got %0d expected 29", lat); end
        for (int c = 0; c <= 10; c++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold%0d_valid: got %b expected 1", c, out_valid); end
            checks++; if (out_y !== 32'h3EAAAAAB) begin failures++; $display("FAIL hold%0d_y: got %h expected 3eaaaaab", c, out_y); end
            checks++; if (out_flags !== 5'b00001) begin failures++; $display("FAIL hold%0d_flags: got %b expected 00001", c, out_flags); end
            checks++; if (out_tag !== 4'hA) begin failures++; $display("FAIL hold%0d_tag: got %h expected a", c, out_tag); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold%0d_in_ready: got %b expected 0", c, in_ready); end
            if (c < 10) begin @(posedge clk); #1; end
        end
        consume();
    endtask

    task automatic test_specials();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] vy [5];
        logic [4:0]  vf [5];
        int lat, rh;
        va = '{32'h00000000, 32'h3F800000, 32'h7F800000, 32'h40000000, 32'h7F800001};
        vb = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h7F800000, 32'h3F800000};
        vy = '{32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h00000000, 32'h7FC00000};
        vf = '{5'b10000,     5'b01000,     5'b10000,     5'b00000,     5'b10000};
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i], 4'(i), lat, rh);
            checks++; if (lat !== 2) begin failures++; $display("FAIL special%0d_latency: got %0d expected 2", i, lat); end
            checks++; if (out_y !== vy[i]) begin failures++; $display("FAIL special%0d_y: got %h expected %h", i, out_y, vy[i]); end
            checks++; if (out_flags !== vf[i]) begin failures++; $display("FAIL special%0d_flags: got %b expected %b", i, out_flags, vf[i]); end
            checks++; if (out_tag !== 4'(i)) begin failures++; $display("FAIL special%0d_tag: got %h expected %h", i, out_tag, 4'(i)); end
            consume();
        end
    endtask

    task automatic test_overflow();
        int lat, rh;
        issue(32'h7F7FFFFF, 32'h3F000000, 4'hC, lat, rh);
        checks++; if (lat !== 29) begin failures++; $display("FAIL overflow_latency: got %0d expected 29", lat); end
        checks++; if (out_y !== 32'h7F800000) begin failures++; $display("FAIL overflow_y: got %h expected 7f800000", out_y); end
        checks++; if (out_flags !== 5'b00101) begin failures++; $display("FAIL overflow_flags: got %b expected 00101", out_flags); end
        consume();
    endtask

    task automatic test_underflow();
        int lat, rh;
        logic [31:0] ey0, ey1;
        logic [4:0]  ef0, ef1;
        int          el1;
`ifdef FPDIV_SUBNORM_EN
        ey0 = 32'h00400000; ef0 = 5'b00000;
        ey1 = 32'h00400000; ef1 = 5'b00000; el1 = 29;
`else
        ey0 = 32'h00000000; ef0 = 5'b00011;
        ey1 = 32'h00000000; ef1 = 5'b00000; el1 = 2;
`endif
        issue(32'h00800000, 32'h40000000, 4'hD, lat, rh);
        checks++; if (lat !== 29) begin failures++; $display("FAIL tiny_latency: got %0d expected 29", lat); end
        checks++; if (out_y !== ey0) begin failures++; $display("FAIL tiny_y: got %h expected %h", out_y, ey0); end
        checks++; if (out_flags !== ef0) begin failures++; $display("FAIL tiny_flags: got %b expected %b", out_flags, ef0); end
        consume();
        issue(32'h00400000, 32'h3F800000, 4'hE, lat, rh);
        checks++; if (lat !== el1) begin failures++; $display("FAIL subin_latency: got %0d expected %0d", lat, el1); end
        checks++; if (out_y !== ey1) begin failures++; $display("FAIL subin_y: got %h expected %h", out_y, ey1); end
        checks++; if (out_flags !== ef1) begin failures++; $display("FAIL subin_flags: got %b expected %b", out_flags, ef1); end
        consume();
    endtask

    task automatic test_reset_mid();
        int cyc, seen, lat, rh;
        in_a = 32'h40C00000; in_b = 32'h40000000; in_tag = 4'h7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 10) begin @(posedge clk); #1; cyc++; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_stale_result: got %0d valid cycles expected 0", seen); end
        issue(32'h40400000, 32'h3FC00000, 4'h3, lat, rh);
        checks++; if (lat !== 29) begin failures++; $display("FAIL midrst_next_latency: got %0d expected 29", lat); end
        checks++; if (out_y !== 32'h40000000) begin failures++; $display("FAIL midrst_next_y: got %h expected 40000000", out_y); end
        checks++; if (out_tag !== 4'h3) begin failures++; $display("FAIL midrst_next_tag: got %h expected 3", out_tag); end
        checks++; if (out_flags !== 5'b0) begin failures++; $display("FAIL midrst_next_flags: got %b expected 00000", out_flags); end
        consume();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        test_reset();
        test_normal();
        test_hold();
        test_specials();
        test_overflow();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_div_iter.md
# fp_div_iter

Parametrised, multi-cycle IEEE-754 binary floating-point divider (radix-2 restoring, one quotient bit per cycle) with valid/ready handshakes on both sides. It generalises the combinational fp32 divider to any exponent/mantissa width and trades latency for area. It sits between the operand-issue logic and the result writeback stage of the FP unit, and carries an opaque tag so requests can be matched to results. It also has complete IEEE special-case handling: x/inf = signed zero, overflow rounds to infinity, and underflow is signalled per IEEE.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- TAG_W, 4, width of the pass-through request tag (≥1)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  divider can accept a request
- in_a  in  W  dividend
- in_b  in  W  divisor
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  W  quotient
- out_tag  out  TAG_W  tag of the accepted request
- out_flags  out  5  {invalid, divzero, overflow, underflow, inexact}

## Operation
- States: IDLE, PREP, ITER, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, register a, b and tag, then go to PREP.
- PREP (1 cycle): unpack, classify, and normalise subnormal mantissas with a leading-zero count.
  - Compute the unbiased exponent difference, width EXP_W+3 signed.
  - Special cases resolve here and go straight to DONE:
    - Any NaN operand → canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0). invalid=1 only if an operand is sNaN (fraction MSB 0).
    - 0/0 and inf/inf → qNaN, invalid.
    - inf/finite → ±inf, no flags.
    - finite/inf → ±0, no flags.
    - 0/nonzero → ±0, no flags.
    - nonzero finite/0 → ±inf, divzero.
  - Otherwise go to ITER.
- ITER: MAN_W+3 cycles. Each cycle shifts the remainder left, compares and subtracts the divisor, and shifts in one quotient bit.
  - Result: quotient of MAN_W+3 bits (integer bit, MAN_W fraction, guard, round) plus sticky = |remainder.
  - The iteration counter is $clog2(MAN_W+4) bits. Leave ITER when the count reaches MAN_W+2.
- ROUND (1 cycle): normalise by at most one bit using the quotient MSB, then round to nearest, ties to even.
  - A mantissa carry-out increments the exponent.
  - Biased exponent ≥ 2^EXP_W−1 after rounding → ±inf, overflow+inexact.
  - Tiny results (biased exponent ≤ 0) are denormalised by a right shift of 1−exp, saturated at MAN_W+2, with all shifted-out bits ORed into sticky, then rounded.
  - Tininess is detected after rounding. underflow = tiny & inexact.
  - A rounding carry into the minimum normal gives exp=1, no underflow.
  - inexact = guard|round|sticky at the final rounding position.
- Sign = sign_a^sign_b for every result except NaN.
- DONE: out_valid=1 with out_y, out_tag and out_flags held stable. On out_ready go to IDLE.
- in_ready is 0 in every state except IDLE. There is one request in flight at a time.
- rst in any state: go to IDLE and abandon the operation; no result is produced.
- Reset values:
  - in_ready=1, out_valid=0.
  - out_y, out_tag and out_flags = 0.

## Timing
- Acceptance edge ends cycle 0.
- Specials: out_valid high from cycle 2.
- Normal operands: PREP in cycle 1, ITER in cycles 2..MAN_W+4, ROUND in cycle MAN_W+5, out_valid high from cycle MAN_W+6 (29 for fp32).
- Minimum request spacing is latency+1 cycles: the DONE→IDLE edge is required before the next accept.
- Combinational paths:
  - No combinational path from in_valid to in_ready.
  - No combinational path from out_ready to out_valid.
  - All outputs are registered.

## Configuration
- FPDIV_SUBNORM_EN defined: full gradual underflow. Subnormal inputs are normalised in PREP, and subnormal results are produced as described above.
- FPDIV_SUBNORM_EN not defined (flush mode):
  - Subnormal inputs are treated as ±0 with no flag, and follow the zero special-case rules.
  - Any result tiny after rounding becomes ±0 with underflow+inexact.
  - The PREP leading-zero normaliser is removed.

## Test plan
- 0x40C00000 / 0x40000000, tag 5 → out_y 0x40400000, flags 0, tag 5, out_valid first high in cycle 29; in_ready low in cycles 1..29.
- 0x3F800000 / 0x40400000 → 0x3EAAAAAB, inexact only. Hold out_ready low for 10 cycles: outputs stay stable and in_ready stays 0.
- Specials, each with out_valid in cycle 2:
  - 0x00000000 / 0x00000000 → 0x7FC00000, invalid.
  - 0x3F800000 / 0x80000000 → 0xFF800000, divzero.
  - 0x7F800000 / 0x7F800000 → 0x7FC00000, invalid.
  - 0x40000000 / 0x7F800000 → 0x00000000, no flags.
  - 0x7F800001 / 0x3F800000 → 0x7FC00000, invalid.
- 0x7F7FFFFF / 0x3F000000 → 0x7F800000, overflow+inexact.
- 0x00800000 / 0x40000000 → with macro 0x00400000, flags 0. Without macro → 0x00000000, underflow+inexact.
- Assert rst in cycle 10 of a normal divide → out_valid never rises for that request, in_ready=1 in the cycle after reset, and the next request completes correctly.
